// File: rtl/ram_stream_buffer_ctrl.sv
// ram_stream_buffer_ctrl
// Turns a dual-port RAM with a one-cycle registered read into a byte FIFO.
// A circular write/fetch pointer pair addresses the RAM, and a 2-entry
// output queue absorbs the read latency so the consumer sees a
// first-word-fall-through valid/ready stream at one byte per cycle.
module ram_stream_buffer_ctrl #(
    parameter int unsigned ADDR_WIDTH        = 14,
    parameter int unsigned ALMOST_FULL_LEVEL = (1 << ADDR_WIDTH) - 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] ram_write_address,
    output logic [7:0]            ram_data_in,
    output logic                  ram_write,
    output logic                  ram_write_enable,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    output logic                  ram_read,
    output logic                  ram_read_enable,
    input  logic [7:0]            ram_data_out,
    output logic [ADDR_WIDTH+1:0] count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   PTR_ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH+1:0] AF_LEVEL    = (ADDR_WIDTH+2)'(ALMOST_FULL_LEVEL);

    // Pointers carry an extra wrap bit so wp - fp spans 0..DEPTH.
    logic [ADDR_WIDTH:0] wp;
    logic [ADDR_WIDTH:0] fp;
    logic [ADDR_WIDTH:0] ram_words;
    logic                inflight;
    logic [1:0]          q_count;
    logic [7:0]          q_head;
    logic [7:0]          q_second;
    logic                accept;
    logic                fetch;
    logic                pop;
    logic [2:0]          q_after_pop;

    // Occupancy, handshakes, fetch decision and RAM strobes
    always_comb begin
        ram_words   = wp - fp;
        full        = (ram_words == DEPTH_WORDS);
        in_ready    = !flush && !full;
        // in_ready stays high through reset, but the RAM must never see a
        // write strobe while reset_n is low.
        accept      = reset_n && in_valid && in_ready;
        out_valid   = (q_count != 2'd0);
        out_data    = q_head;
        pop         = out_valid && out_ready;
        // Queue occupancy once this cycle's landing and pop are applied;
        // a new fetch is only issued if it will have a free slot to land in.
        q_after_pop = {1'b0, q_count} + {2'b00, inflight} - {2'b00, pop};
        fetch       = !flush && (ram_words != '0) && (q_after_pop < 3'd2);

        ram_write_address = wp[ADDR_WIDTH-1:0];
        ram_data_in       = in_data;
        ram_write         = accept;
        ram_write_enable  = accept;
        ram_read_address  = fp[ADDR_WIDTH-1:0];
        ram_read          = fetch;
        ram_read_enable   = fetch;

        count       = (ADDR_WIDTH+2)'(ram_words) + (ADDR_WIDTH+2)'(inflight)
                    + (ADDR_WIDTH+2)'(q_count);
        empty       = (count == '0);
        almost_full = (count >= AF_LEVEL);
    end

    // Write/fetch pointers and the one-cycle read-in-flight marker
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp       <= '0;
            fp       <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            wp       <= '0;
            fp       <= '0;
            inflight <= 1'b0;
        end else begin
            if (accept) wp <= wp + PTR_ONE;
            if (fetch)  fp <= fp + PTR_ONE;
            inflight <= fetch;
        end
    end

    // Two-entry output queue: landing RAM data at the tail, pops from the head
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_count  <= '0;
            q_head   <= '0;
            q_second <= '0;
        end else if (flush) begin
            q_count <= '0;
        end else begin
            case ({inflight, pop})
                2'b01: begin
                    q_head  <= q_second;
                    q_count <= q_count - 2'd1;
                end
                2'b10: begin
                    if (q_count == 2'd0) q_head   <= ram_data_out;
                    else                 q_second <= ram_data_out;
                    q_count <= q_count + 2'd1;
                end
                2'b11: begin
                    if (q_count == 2'd1) begin
                        q_head <= ram_data_out;
                    end else begin
                        q_head   <= q_second;
                        q_second <= ram_data_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_buffer_ctrl.sv
// Testbench for ram_stream_buffer_ctrl: a RAM model with registered read
// plus a byte-queue reference model. A byte accepted in cycle N must be
// visible at the head from cycle N+3 onward, in order, until popped.
module tb_ram_stream_buffer_ctrl;

    localparam int unsigned AW    = 14;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned AF    = DEPTH - 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          flush;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] ram_write_address;
    logic [7:0]    ram_data_in;
    logic          ram_write;
    logic          ram_write_enable;
    logic [AW-1:0] ram_read_address;
    logic          ram_read;
    logic          ram_read_enable;
    logic [7:0]    ram_data_out;
    logic [AW+1:0] count;
    logic          full;
    logic          empty;
    logic          almost_full;

    always #5 clock = ~clock;

    ram_stream_buffer_ctrl #(.ADDR_WIDTH(AW), .ALMOST_FULL_LEVEL(AF)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .ram_write_address(ram_write_address), .ram_data_in(ram_data_in),
        .ram_write(ram_write), .ram_write_enable(ram_write_enable),
        .ram_read_address(ram_read_address), .ram_read(ram_read),
        .ram_read_enable(ram_read_enable), .ram_data_out(ram_data_out),
        .count(count), .full(full), .empty(empty), .almost_full(almost_full)
    );

    // 16Kx8 dual-port RAM, registered read
    logic [7:0] mem [DEPTH];
    always @(posedge clock) begin
        if (ram_write) mem[ram_write_address] <= ram_data_in;
        if (ram_read)  ram_data_out <= mem[ram_read_address];
    end

    typedef struct { logic [7:0] data; int unsigned cyc; } entry_t;
    entry_t      model[$];
    int unsigned cyc = 0, wr_total = 0, rd_total = 0, pop_total = 0;
    int unsigned checks = 0, passes = 0;

    logic          o_valid, o_ready, o_full, o_empty, o_af, o_wr, o_wen, o_rd, o_ren;
    logic          acc, pop_ev;
    logic [7:0]    o_data, o_din;
    logic [AW-1:0] o_waddr, o_raddr;
    logic [AW+1:0] o_count;
    logic          e_valid;
    logic [7:0]    e_data;
    logic [AW+1:0] e_count;
    logic [AW-1:0] e_waddr, e_raddr;
    int unsigned   e_out_side;

    task automatic model_clear();
        model.delete();
        wr_total  = 0;
        rd_total  = 0;
        pop_total = 0;
    endtask

    // One clock cycle: drive, sample mid-cycle, then advance the model at the edge.
    task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        entry_t ent;
        in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
        @(negedge clock);
        o_valid = out_valid; o_data = out_data; o_count = count; o_ready = in_ready;
        o_full = full; o_empty = empty; o_af = almost_full;
        o_wr = ram_write; o_wen = ram_write_enable; o_waddr = ram_write_address; o_din = ram_data_in;
        o_rd = ram_read; o_ren = ram_read_enable; o_raddr = ram_read_address;
        e_count = (AW+2)'(model.size());
        e_valid = 1'b0;
        e_data  = '0;
        if (model.size() != 0) begin
            e_valid = (model[0].cyc + 3 <= cyc);
            e_data  = model[0].data;
        end
        e_waddr    = AW'(wr_total);
        e_raddr    = AW'(rd_total);
        e_out_side = rd_total - pop_total;
        acc        = iv & o_ready;
        pop_ev     = o_valid & ordy;
        @(posedge clock);
        if (fl) begin
            model_clear();
        end else begin
            if (o_rd) rd_total++;
            if (pop_ev) begin
                pop_total++;
                if (model.size() != 0) model.delete(0);
            end
            if (acc) begin
                ent.data = d; ent.cyc = cyc;
                model.push_back(ent);
                wr_total++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
        #1 reset_n = 1'b0;
        #2;
        checks++; if ({out_valid, out_data, count} !== '0) $display("FAIL reset_out got valid=%b data=%h count=%0d want 0/00/0", out_valid, out_data, count); else passes++;
        checks++; if ({empty, full, almost_full} !== 3'b100) $display("FAIL reset_flags got e/f/af=%b%b%b want 100", empty, full, almost_full); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passes++;
        checks++; if ({ram_write, ram_read, ram_write_address, ram_read_address} !== '0) $display("FAIL reset_strobes got wr=%b rd=%b wa=%0d ra=%0d want all 0", ram_write, ram_read, ram_write_address, ram_read_address); else passes++;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b1;
    endtask

    task automatic test_single_byte();
        int ev[5] = '{0, 0, 0, 1, 0};
        int ec[5] = '{0, 1, 1, 1, 0};
        int er[5] = '{0, 1, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            step(i == 0, 8'hA5, 1'b1, 1'b0);
            checks++; if (o_valid !== (ev[i] != 0)) $display("FAIL single_valid c%0d got %b want %0d", i, o_valid, ev[i]); else passes++;
            checks++; if (int'(o_count) != ec[i]) $display("FAIL single_count c%0d got %0d want %0d", i, o_count, ec[i]); else passes++;
            checks++; if (o_rd !== (er[i] != 0)) $display("FAIL single_read c%0d got %b want %0d", i, o_rd, er[i]); else passes++;
            if (i == 0) begin
                checks++; if ({o_wr, o_wen, o_waddr, o_din} !== {2'b11, 14'd0, 8'hA5}) $display("FAIL single_write got wr=%b we=%b a=%0d d=%h want 1/1/0/a5", o_wr, o_wen, o_waddr, o_din); else passes++;
            end
            if (i == 1) begin
                checks++; if ({o_ren, o_raddr} !== {1'b1, 14'd0}) $display("FAIL single_raddr got re=%b a=%0d want 1/0", o_ren, o_raddr); else passes++;
            end
            if (i == 3) begin
                checks++; if (o_data !== 8'hA5) $display("FAIL single_data got %h want a5", o_data); else passes++;
            end
        end
    endtask

    task automatic test_streaming();
        int first = -1, last = -1;
        for (int i = 0; i < 1006; i++) begin
            step(i < 1000, 8'(i), 1'b1, 1'b0);
            checks++; if (o_valid !== e_valid) $display("FAIL stream_valid i=%0d got %b want %b", i, o_valid, e_valid); else passes++;
            if (o_valid) begin
                checks++; if (o_data !== e_data) $display("FAIL stream_data i=%0d got %h want %h", i, o_data, e_data); else passes++;
                if (first < 0) first = i;
                last = i;
            end
            checks++; if (o_count !== e_count) $display("FAIL stream_count i=%0d got %0d want %0d", i, o_count, e_count); else passes++;
            checks++; if (o_empty !== (e_count == 0)) $display("FAIL stream_empty i=%0d got %b want %b", i, o_empty, e_count == 0); else passes++;
        end
        checks++; if (first != 3 || last != 1002) $display("FAIL stream_gapless got first=%0d last=%0d want 3/1002", first, last); else passes++;
        checks++; if (o_empty !== 1'b1) $display("FAIL stream_drained got empty=%b want 1", o_empty); else passes++;
    endtask

    task automatic test_fill_full();
        int unsigned accepted = 0;
        bit stopped = 0;
        for (int i = 0; i < int'(DEPTH) + 10 && !stopped; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0);
            checks++; if (o_count !== e_count) $display("FAIL fill_count i=%0d got %0d want %0d", i, o_count, e_count); else passes++;
            checks++; if (o_af !== (e_count >= AF)) $display("FAIL fill_almost_full count=%0d got %b want %b", e_count, o_af, e_count >= AF); else passes++;
            checks++; if (o_full !== !o_ready) $display("FAIL fill_full_vs_ready got full=%b in_ready=%b want complementary", o_full, o_ready); else passes++;
            if (e_count < DEPTH) begin
                checks++; if (o_ready !== 1'b1) $display("FAIL fill_in_ready count=%0d got %b want 1", e_count, o_ready); else passes++;
            end
            if (acc) begin
                checks++; if (o_waddr !== e_waddr) $display("FAIL fill_waddr got %0d want %0d", o_waddr, e_waddr); else passes++;
                accepted++;
            end else begin
                stopped = 1;
            end
        end
        checks++; if (accepted != DEPTH + 2) $display("FAIL fill_accepts got %0d want %0d", accepted, DEPTH + 2); else passes++;
        checks++; if (int'(o_count) != int'(DEPTH) + 2 || o_full !== 1'b1) $display("FAIL fill_full got count=%0d full=%b want %0d/1", o_count, o_full, DEPTH + 2); else passes++;
        for (int i = 0; i < int'(DEPTH) + 20 && model.size() != 0; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            checks++; if (o_valid !== e_valid) $display("FAIL drain_valid i=%0d got %b want %b", i, o_valid, e_valid); else passes++;
            if (o_valid) begin
                checks++; if (o_data !== e_data) $display("FAIL drain_data i=%0d got %h want %h", i, o_data, e_data); else passes++;
            end
            if (o_rd) begin
                checks++; if (o_raddr !== e_raddr) $display("FAIL drain_raddr got %0d want %0d", o_raddr, e_raddr); else passes++;
            end
        end
        checks++; if (model.size() != 0) $display("FAIL drain_timeout got %0d bytes left want 0", model.size()); else passes++;
    endtask

    task automatic test_wrap();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8200; i++) begin
                if (i >= 6000 && model.size() == 0) break;
                step(i < 6000, 8'($urandom), i >= 2000, 1'b0);
                checks++; if (o_valid !== e_valid) $display("FAIL wrap_valid r=%0d i=%0d got %b want %b", r, i, o_valid, e_valid); else passes++;
                if (o_valid) begin
                    checks++; if (o_data !== e_data) $display("FAIL wrap_data r=%0d i=%0d got %h want %h", r, i, o_data, e_data); else passes++;
                end
                checks++; if (o_count !== e_count || int'(o_count) > int'(DEPTH) + 2) $display("FAIL wrap_count r=%0d i=%0d got %0d want %0d", r, i, o_count, e_count); else passes++;
                if (acc) begin
                    checks++; if (o_waddr !== e_waddr) $display("FAIL wrap_waddr got %0d want %0d", o_waddr, e_waddr); else passes++;
                end
                if (o_rd) begin
                    checks++; if (o_raddr !== e_raddr) $display("FAIL wrap_raddr got %0d want %0d", o_raddr, e_raddr); else passes++;
                end
            end
            checks++; if (model.size() != 0) $display("FAIL wrap_timeout r=%0d got %0d bytes left want 0", r, model.size()); else passes++;
        end
    endtask

    task automatic test_backpressure();
        int unsigned sent = 0;
        logic iv, ordy;
        for (int i = 0; i < 20000; i++) begin
            if (sent >= 4000 && model.size() == 0) break;
            iv   = (sent < 4000) && ($urandom_range(0, 9) < 7);
            ordy = 1'($urandom_range(0, 1));
            step(iv, 8'($urandom), ordy, 1'b0);
            if (acc) sent++;
            checks++; if (o_valid !== e_valid) $display("FAIL bp_valid i=%0d got %b want %b", i, o_valid, e_valid); else passes++;
            if (o_valid) begin
                checks++; if (o_data !== e_data) $display("FAIL bp_data i=%0d got %h want %h", i, o_data, e_data); else passes++;
            end
            checks++; if (o_count !== e_count) $display("FAIL bp_count i=%0d got %0d want %0d", i, o_count, e_count); else passes++;
            checks++; if (e_out_side + int'(o_rd) - int'(pop_ev) > 2) $display("FAIL bp_fetch_limit i=%0d got %0d bytes out of RAM want <=2", i, e_out_side + int'(o_rd) - int'(pop_ev)); else passes++;
            if (iv) begin
                checks++; if (o_ready !== 1'b1) $display("FAIL bp_in_ready i=%0d got %b want 1", i, o_ready); else passes++;
            end
        end
        checks++; if (sent != 4000 || model.size() != 0) $display("FAIL bp_timeout got sent=%0d left=%0d want 4000/0", sent, model.size()); else passes++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 100; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        checks++; if ({o_valid, o_rd} !== 2'b11) $display("FAIL flush_setup got valid=%b fetch=%b want 1/1", o_valid, o_rd); else passes++;
        step(1'b1, 8'h77, 1'b0, 1'b1);
        checks++; if ({o_ready, o_wr, o_rd} !== 3'b000) $display("FAIL flush_cycle got in_ready=%b wr=%b rd=%b want 000", o_ready, o_wr, o_rd); else passes++;
        checks++; if (int'(o_count) != 99) $display("FAIL flush_precount got %0d want 99", o_count); else passes++;
        for (int i = 0; i < 6; i++) begin
            step(i == 0, 8'h5A, 1'b1, 1'b0);
            if (i == 0) begin
                checks++; if ({o_count, o_valid, o_empty} !== {16'd0, 2'b01}) $display("FAIL flush_cleared got count=%0d valid=%b empty=%b want 0/0/1", o_count, o_valid, o_empty); else passes++;
                checks++; if (o_waddr !== '0) $display("FAIL flush_waddr got %0d want 0", o_waddr); else passes++;
            end
            checks++; if (o_valid !== (i == 3)) $display("FAIL flush_next_valid i=%0d got %b want %b", i, o_valid, i == 3); else passes++;
            if (i == 3) begin
                checks++; if (o_data !== 8'h5A) $display("FAIL flush_next_data got %h want 5a", o_data); else passes++;
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 50; i++) step(1'b1, 8'($urandom), i > 20, 1'b0);
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({out_valid, out_data, count} !== '0) $display("FAIL areset_out got valid=%b data=%h count=%0d want 0/00/0", out_valid, out_data, count); else passes++;
        checks++; if ({empty, full, almost_full, in_ready} !== 4'b1001) $display("FAIL areset_flags got e/f/af/ir=%b%b%b%b want 1001", empty, full, almost_full, in_ready); else passes++;
        checks++; if ({ram_write, ram_read, ram_write_address, ram_read_address} !== '0) $display("FAIL areset_strobes got wr=%b rd=%b wa=%0d ra=%0d want all 0", ram_write, ram_read, ram_write_address, ram_read_address); else passes++;
        model_clear();
        @(posedge clock); cyc++;
        #1;
        in_valid = 1'b0;
        reset_n  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(i == 0, 8'hC3, 1'b1, 1'b0);
            checks++; if (o_valid !== e_valid || (o_valid && o_data !== e_data)) $display("FAIL areset_recover i=%0d got valid=%b data=%h want %b/%h", i, o_valid, o_data, e_valid, e_data); else passes++;
            checks++; if (o_count !== e_count) $display("FAIL areset_count i=%0d got %0d want %0d", i, o_count, e_count); else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_streaming();
        test_fill_full();
        test_wrap();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got still running at %0t want finished earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
